// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared types and helpers for the instruction fetch stage.
//   fetch_state_t : fetch FSM state (IDLE / BUSY / DROP)
//   fetch_entry_t : one prefetch buffer entry {insn, ip}
//   align_ip      : clears bit0 (instructions are 16-bit aligned)
//   next_ip       : sequential fetch address, wraps at 16 bits
package cpu_fetch_pkg;

  localparam int INSN_W = 16;
  localparam int IP_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    BUSY = 2'd1,  // request outstanding, response will be kept
    DROP = 2'd2   // request outstanding, response will be discarded
  } fetch_state_t;

  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [IP_W-1:0]   ip;
  } fetch_entry_t;

  function automatic logic [IP_W-1:0] align_ip(input logic [IP_W-1:0] ip);
    return ip & ~IP_W'(1);
  endfunction

  function automatic logic [IP_W-1:0] next_ip(input logic [IP_W-1:0] ip);
    return ip + IP_W'(2);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t used as the prefetch buffer.
// Ports:
//   clk, rst_n          clock, async active-low reset (storage cleared to 0)
//   i_push, i_wdata     write an entry (accepted when not full, or full with pop)
//   i_pop               remove head entry (ignored when empty)
//   i_flush             empty the FIFO; dominates push and pop
//   o_rdata             head entry (registered storage)
//   o_full, o_empty     status
//   o_count             number of valid entries
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  fetch_entry_t               i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_push, w_do_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  // a push into a full FIFO is only legal when the head leaves the same cycle
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/insn_fetch.sv
// insn_fetch: instruction fetch stage feeding the decoder.
// Issues one 16-bit read at a time to instruction memory, buffers returned
// words with their addresses in a prefetch FIFO, and hands them to decode via
// insn_valid/insn_ready. A redirect flushes the buffer and restarts fetch; an
// in-flight read cannot be aborted, so its response is discarded (DROP).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   mem_req, mem_addr          fetch request, held until mem_ack
//   mem_ack, mem_rdata         one-cycle response pulse and data
//   insn, insn_ip, insn_valid  instruction, its address, valid
//   insn_ready                 consumer accepts insn this cycle
//   redirect, redirect_ip      flush and restart fetch at redirect_ip
// Optional: define INSN_FETCH_BYPASS_EN to forward a returning word straight
// to insn in the ack cycle when the buffer is empty (zero latency).
module insn_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [IP_W-1:0] RESET_IP = 16'h0000,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [IP_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INSN_W-1:0] mem_rdata,
  output logic [INSN_W-1:0] insn,
  output logic [IP_W-1:0]   insn_ip,
  output logic              insn_valid,
  input  logic              insn_ready,
  input  logic              redirect,
  input  logic [IP_W-1:0]   redirect_ip
);

  localparam int              CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [IP_W-1:0] RST_PC = align_ip(RESET_IP);

  fetch_state_t     r_state, w_state_nxt;
  logic [IP_W-1:0]  r_pc, w_pc_nxt;
  logic [IP_W-1:0]  r_mem_addr, w_addr_nxt;
  logic [IP_W-1:0]  w_redir_pc;
  logic             w_ack_keep, w_push, w_pop;
  logic             w_full, w_empty, w_unused_full;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head, w_wdata;

  assign w_redir_pc = align_ip(redirect_ip);
  // response that will actually be delivered (not cancelled by a redirect)
  assign w_ack_keep = (r_state == BUSY) && mem_ack && !redirect;
  assign w_wdata    = '{insn: mem_rdata, ip: r_mem_addr};
  // full is implied by count; issue is gated on count directly
  assign w_unused_full = w_full;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // redirect wins over pop: the head being presented is stale
  assign w_pop = !w_empty && insn_ready && !redirect;

`ifdef INSN_FETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass   = w_empty && w_ack_keep;
  assign insn       = w_bypass ? mem_rdata  : w_head.insn;
  assign insn_ip    = w_bypass ? r_mem_addr : w_head.ip;
  assign insn_valid = !w_empty || w_bypass;
  // a bypassed word that is consumed immediately never enters the FIFO
  assign w_push     = w_ack_keep && !(w_bypass && insn_ready);
`else
  assign insn       = w_head.insn;
  assign insn_ip    = w_head.ip;
  assign insn_valid = !w_empty;
  assign w_push     = w_ack_keep;
`endif

  assign mem_req  = (r_state != IDLE);
  assign mem_addr = r_mem_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RST_PC;
      r_mem_addr <= RST_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_mem_addr <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_mem_addr;
    case (r_state)
      IDLE: begin
        // acks seen here belong to nobody (e.g. across a reset) and are ignored
        if (redirect) begin
          // FIFO is flushed this edge, so there is always room
          w_pc_nxt    = w_redir_pc;
          w_addr_nxt  = w_redir_pc;
          w_state_nxt = BUSY;
        end else if (w_count < CNT_W'(DEPTH)) begin
          // only the issuing request can ever land, so room now means room later
          w_addr_nxt  = r_pc;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          w_pc_nxt    = next_ip(r_mem_addr);
          w_state_nxt = IDLE;
        end
      end
      DROP: begin
        if (redirect) w_pc_nxt = w_redir_pc;
        if (mem_ack)  w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
